// File: rtl/iec_sd_pkg.sv
// Shared types and constants for the IEC drive-to-host SD block-port arbiter.
package iec_sd_pkg;

  localparam int unsigned MAX_DRIVES = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    XFER,
    DONE
  } state_e;

  typedef struct packed {
    logic [31:0] lba;
    logic [5:0]  blk_cnt;
    logic        rd;
    logic        wr;
  } drv_req_t;

  function automatic int unsigned ndr_clamp(input int unsigned drives);
    if (drives < 1) return 1;
    if (drives > MAX_DRIVES) return MAX_DRIVES;
    return drives;
  endfunction

endpackage

// File: rtl/iec_sd_arbiter_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping modulo NDR.
module iec_rr_pick
  import iec_sd_pkg::*;
#(
  parameter  int unsigned NDR = 2,
  localparam int unsigned N   = NDR - 1
) (
  input  logic [N:0]                        req,
  input  logic [$clog2(MAX_DRIVES)-1:0]     last,
  output logic                              valid,
  output logic [$clog2(MAX_DRIVES)-1:0]     idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NDR; k++) begin
      for (int unsigned j = 0; j < NDR; j++) begin
        if (!valid && req[j] && (((k + {30'b0, last}) % NDR) == j)) begin
          valid = 1'b1;
          idx   = 2'(j);
        end
      end
    end
  end

endmodule

// File: rtl/iec_sd_arbiter.sv
// Shares one host SD block port between up to four drives: round-robin grant,
// per-grant latching of LBA/count/direction, buffer routing and ack timeout.
module iec_sd_arbiter
  import iec_sd_pkg::*;
#(
  parameter  int unsigned DRIVES  = 2,
  parameter  logic [23:0] TIMEOUT = 24'd12000000,
  localparam int unsigned NDR     = ndr_clamp(DRIVES),
  localparam int unsigned N       = NDR - 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [N:0]        img_mounted,
  input  logic [32*NDR-1:0] drv_lba,
  input  logic [6*NDR-1:0]  drv_blk_cnt,
  input  logic [N:0]        drv_rd,
  input  logic [N:0]        drv_wr,
  output logic [N:0]        drv_ack,
  input  logic [8*NDR-1:0]  drv_buff_din,
  output logic [31:0]       sd_lba,
  output logic [5:0]        sd_blk_cnt,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  output logic [7:0]        sd_buff_din,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              timeout_err
);

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] lba_q, lba_d;
  logic [5:0]  blk_q, blk_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [N:0]  ack_q, ack_d;
  logic        terr_q, terr_d;
  logic [23:0] cnt_q, cnt_d;

  drv_req_t    req_rec [NDR];
  logic [N:0]  req_v;
  logic        pick_valid;
  logic [1:0]  pick_idx;
  drv_req_t    pick_rec;
  logic        mnt_g;
  logic [N:0]  ack_oh;

  always_comb begin
    req_v = '0;
    for (int unsigned i = 0; i < NDR; i++) begin
      req_rec[i] = '{lba: drv_lba[32*i +: 32], blk_cnt: drv_blk_cnt[6*i +: 6],
                     rd: drv_rd[i], wr: drv_wr[i]};
      req_v[i]   = drv_rd[i] | drv_wr[i];
    end
  end

  iec_rr_pick #(.NDR(NDR)) u_pick (
    .req   (req_v),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Index-by-compare keeps every select in range whatever NDR is.
  always_comb begin
    pick_rec    = '0;
    mnt_g       = 1'b0;
    ack_oh      = '0;
    sd_buff_din = '0;
    for (int unsigned i = 0; i < NDR; i++) begin
      if (pick_idx == 2'(i)) pick_rec = req_rec[i];
      if (grant_q == 2'(i)) begin
        mnt_g       = img_mounted[i];
        ack_oh[i]   = 1'b1;
        sd_buff_din = drv_buff_din[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    lba_d   = lba_q;
    blk_d   = blk_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ack_d   = ack_q;
    terr_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          lba_d   = pick_rec.lba;
          blk_d   = pick_rec.blk_cnt;
          wr_d    = pick_rec.wr;
          rd_d    = pick_rec.rd & ~pick_rec.wr;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ack_d   = ack_oh;
          state_d = XFER;
        end else if (mnt_g) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          last_d  = grant_q;
          state_d = IDLE;
        end else if (TIMEOUT != '0 && cnt_q >= TIMEOUT - 24'd1) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          terr_d  = 1'b1;
          last_d  = grant_q;
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      XFER: begin
        ack_d = sd_ack ? ack_oh : '0;
        if (!sd_ack) state_d = DONE;
      end
      DONE: begin
        ack_d   = '0;
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 2'(N);
      lba_q   <= '0;
      blk_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= '0;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      lba_q   <= lba_d;
      blk_q   <= blk_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign drv_ack     = ack_q;
  assign sd_lba      = lba_q;
  assign sd_blk_cnt  = blk_q;
  assign sd_rd       = rd_q;
  assign sd_wr       = wr_q;
  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_iec_sd_arbiter.sv
// Bench for iec_sd_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_iec_sd_arbiter;

  localparam int ND = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [3:0]   img_mounted = '0;
  logic [127:0] drv_lba = '0;
  logic [23:0]  drv_blk_cnt = '0;
  logic [3:0]   drv_rd = '0;
  logic [3:0]   drv_wr = '0;
  logic [3:0]   drv_ack;
  logic [31:0]  drv_buff_din = '0;
  logic [31:0]  sd_lba;
  logic [5:0]   sd_blk_cnt;
  logic         sd_rd, sd_wr;
  logic         sd_ack = 1'b0;
  logic [7:0]   sd_buff_din;
  logic [1:0]   grant;
  logic         busy, timeout_err;

  always #5 clk = ~clk;

  iec_sd_arbiter #(.DRIVES(ND), .TIMEOUT(24'd16)) dut (
    .clk_sys      (clk),
    .reset_n      (reset_n),
    .img_mounted  (img_mounted),
    .drv_lba      (drv_lba),
    .drv_blk_cnt  (drv_blk_cnt),
    .drv_rd       (drv_rd),
    .drv_wr       (drv_wr),
    .drv_ack      (drv_ack),
    .drv_buff_din (drv_buff_din),
    .sd_lba       (sd_lba),
    .sd_blk_cnt   (sd_blk_cnt),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_din  (sd_buff_din),
    .grant        (grant),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction-level model: one outstanding request, what it is, how long it has waited.
  bit          m_pending = 0, m_in_xfer = 0, m_tail = 0, m_ack = 0, m_terr = 0, m_wr = 0;
  int          m_grant = 0, m_last = ND - 1, m_wait = 0;
  logic [31:0] m_lba = '0;
  logic [5:0]  m_blk = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pending = 0; m_in_xfer = 0; m_tail = 0; m_ack = 0; m_terr = 0; m_wr = 0;
      m_grant = 0; m_last = ND - 1; m_wait = 0; m_lba = '0; m_blk = '0;
    end else begin
      m_terr = 0;
      if (m_tail) begin
        m_tail = 0;
        m_last = m_grant;
      end else if (m_in_xfer) begin
        m_ack = sd_ack;
        if (!sd_ack) begin m_in_xfer = 0; m_tail = 1; end
      end else if (m_pending) begin
        if (sd_ack) begin
          m_pending = 0; m_in_xfer = 1; m_ack = 1;
        end else if (img_mounted[m_grant]) begin
          m_pending = 0; m_last = m_grant;
        end else if (m_wait + 1 >= TO) begin
          m_pending = 0; m_terr = 1; m_last = m_grant;
        end else begin
          m_wait++;
        end
      end else begin
        for (int k = 1; k <= ND; k++) begin
          int c;
          c = (m_last + k) % ND;
          if (!m_pending && (drv_rd[c] || drv_wr[c])) begin
            m_pending = 1;
            m_grant   = c;
            m_lba     = drv_lba[c*32 +: 32];
            m_blk     = drv_blk_cnt[c*6 +: 6];
            m_wr      = drv_wr[c];
            m_wait    = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("sd_rd",       64'(sd_rd),       64'(m_pending && !m_wr));
      chk("sd_wr",       64'(sd_wr),       64'(m_pending && m_wr));
      chk("busy",        64'(busy),        64'(m_pending || m_in_xfer || m_tail));
      chk("grant",       64'(grant),       64'(m_grant));
      chk("drv_ack",     64'(drv_ack),     64'(m_ack ? (4'b1 << m_grant) : 4'b0));
      chk("sd_lba",      64'(sd_lba),      64'(m_lba));
      chk("sd_blk_cnt",  64'(sd_blk_cnt),  64'(m_blk));
      chk("timeout_err", 64'(timeout_err), 64'(m_terr));
      chk("sd_buff_din", 64'(sd_buff_din), 64'(drv_buff_din[m_grant*8 +: 8]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    img_mounted = '0; drv_rd = '0; drv_wr = '0; sd_ack = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  int          n_hi, n_terr, next_g, w;
  bit          seen_terr;
  int          exp_seq [6] = '{0, 1, 2, 3, 0, 1};
  bit          req_on [ND];
  int          h_dly, h_len;
  logic [1:0]  r;

  initial begin
    // Reset state
    do_reset();
    chk_on = 1'b1;
    chk("rst_sd_rd", 64'(sd_rd), 64'd0);
    chk("rst_busy",  64'(busy),  64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_ack",   64'(drv_ack), 64'd0);

    // Single read with a long host ack
    drv_lba[31:0] = 32'h168; drv_blk_cnt[5:0] = 6'd0; drv_rd[0] = 1'b1;
    tick();
    chk("rd_issue",  64'(sd_rd), 64'd1);
    chk("rd_lba",    64'(sd_lba), 64'h168);
    chk("rd_blk",    64'(sd_blk_cnt), 64'd0);
    sd_ack = 1'b1;
    tick();
    chk("rd_ack_lag", 64'(drv_ack), 64'd1);
    drv_rd[0] = 1'b0;
    repeat (511) tick();
    chk("rd_ack_hold", 64'(drv_ack), 64'd1);
    sd_ack = 1'b0;
    tick();
    chk("rd_ack_drop", 64'(drv_ack), 64'd0);
    chk("rd_busy_done", 64'(busy), 64'd1);
    tick();
    chk("rd_busy_idle", 64'(busy), 64'd0);

    // Round robin with all four requesting continuously
    do_reset();
    for (int i = 0; i < ND; i++) drv_lba[i*32 +: 32] = 32'h1000 + 32'(i);
    drv_rd = 4'hF;
    for (int t = 0; t < 6; t++) begin
      w = 0;
      while (!sd_rd && w < 12) begin tick(); w++; end
      chk("rr_wait", 64'(sd_rd), 64'd1);
      chk("rr_grant", 64'(grant), 64'(exp_seq[t]));
      sd_ack = 1'b1;
      tick(); tick();
      sd_ack = 1'b0;
      tick();
    end
    drv_rd = '0;
    repeat (4) tick();

    // Write wins over read; buffer routed from the granted drive
    do_reset();
    drv_buff_din = {16'h0, 8'hA5, 8'h3C};
    drv_rd[1] = 1'b1; drv_wr[1] = 1'b1;
    tick();
    chk("wp_wr",    64'(sd_wr), 64'd1);
    chk("wp_rd",    64'(sd_rd), 64'd0);
    chk("wp_buf",   64'(sd_buff_din), 64'hA5);
    chk("wp_grant", 64'(grant), 64'd1);
    sd_ack = 1'b1;
    tick();
    chk("wp_buf_xfer", 64'(sd_buff_din), 64'hA5);
    chk("wp_ack",      64'(drv_ack), 64'b0010);
    drv_rd = '0; drv_wr = '0;
    tick();
    sd_ack = 1'b0;
    tick(); tick();
    chk("wp_buf_idle", 64'(sd_buff_din), 64'hA5);

    // Timeout on drive 1, then arbitration resumes after it
    do_reset();
    drv_rd[1] = 1'b1;
    tick();
    n_hi = (sd_rd && grant == 2'd1) ? 1 : 0;
    n_terr = 0; seen_terr = 0; next_g = -1;
    drv_rd[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sd_rd && grant == 2'd1 && !seen_terr) n_hi++;
      if (timeout_err) begin n_terr++; seen_terr = 1; end
      if (seen_terr && next_g < 0 && sd_rd) next_g = int'(grant);
    end
    chk("to_hi_cycles", 64'(n_hi), 64'd16);
    chk("to_pulse",     64'(n_terr), 64'd1);
    chk("to_next",      64'(next_g), 64'd0);

    // Mount pulse while drive 0 is still waiting for ack cancels it
    drv_rd = '0; img_mounted[0] = 1'b1;
    tick();
    img_mounted = '0;
    chk("mnt_issue_rd",   64'(sd_rd), 64'd0);
    chk("mnt_issue_busy", 64'(busy), 64'd0);

    // Mount pulse during a transfer is ignored
    drv_rd[0] = 1'b1;
    tick();
    sd_ack = 1'b1;
    tick();
    drv_rd = '0; img_mounted[0] = 1'b1;
    tick();
    img_mounted = '0;
    chk("mnt_xfer_ack",  64'(drv_ack), 64'd1);
    chk("mnt_xfer_busy", 64'(busy), 64'd1);
    sd_ack = 1'b0;
    tick();
    chk("mnt_xfer_done", 64'(busy), 64'd1);
    tick();
    chk("mnt_xfer_idle", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a transfer
    drv_lba[95:64] = 32'hDEAD; drv_blk_cnt[17:12] = 6'd5; drv_rd[2] = 1'b1;
    tick();
    sd_ack = 1'b1;
    tick();
    chk("ar_pre_grant", 64'(grant), 64'd2);
    chk("ar_pre_ack",   64'(drv_ack), 64'b0100);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_ack",   64'(drv_ack), 64'd0);
    chk("ar_grant", 64'(grant), 64'd0);
    chk("ar_busy",  64'(busy), 64'd0);
    chk("ar_lba",   64'(sd_lba), 64'd0);
    chk("ar_blk",   64'(sd_blk_cnt), 64'd0);
    chk("ar_rdwr",  64'({sd_rd, sd_wr}), 64'd0);
    sd_ack = 1'b0; drv_rd = '0;
    tick();
    reset_n = 1'b1;
    tick();

    // Randomized traffic: level requesters, a host with variable ack latency, stray mounts
    do_reset();
    for (int i = 0; i < ND; i++) req_on[i] = 0;
    h_dly = -1; h_len = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      img_mounted = '0;
      for (int i = 0; i < ND; i++) begin
        if (req_on[i] && drv_ack[i]) begin
          drv_rd[i] = 1'b0; drv_wr[i] = 1'b0; req_on[i] = 0;
        end else if (!req_on[i] && ($urandom % 6) == 0) begin
          r = 2'($urandom_range(1, 3));
          drv_rd[i] = r[0]; drv_wr[i] = r[1];
          drv_lba[i*32 +: 32] = $urandom;
          drv_blk_cnt[i*6 +: 6] = 6'($urandom);
          req_on[i] = 1;
        end else if (req_on[i] && ($urandom % 5) == 0) begin
          drv_lba[i*32 +: 32] = $urandom;
          drv_blk_cnt[i*6 +: 6] = 6'($urandom);
        end
        if (($urandom % 80) == 0) img_mounted[i] = 1'b1;
      end
      drv_buff_din = $urandom;
      if (h_len > 0) begin
        h_len--;
        if (h_len == 0) sd_ack = 1'b0;
      end else if (sd_rd || sd_wr) begin
        if (h_dly < 0) h_dly = int'($urandom_range(0, 20));
        if (h_dly == 0) begin
          sd_ack = 1'b1; h_len = int'($urandom_range(1, 8)); h_dly = -1;
        end else begin
          h_dly--; sd_ack = 1'b0;
        end
      end else begin
        h_dly = -1;
        sd_ack = (!busy && ($urandom % 40) == 0);
      end
    end
    drv_rd = '0; drv_wr = '0; img_mounted = '0;
    w = 0;
    while (w < 40) begin
      if (h_len > 0) begin h_len--; if (h_len == 0) sd_ack = 1'b0; end
      else sd_ack = 1'b0;
      tick(); w++;
    end
    chk("end_idle", 64'(busy), 64'd0);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
